snd_rom_fetch: RTL
==================

Name: snd_rom_fetch

Overview:
- Read sequencer between the sound-board CPU bus and the sound program ROM (4 KB, two 2 KB halves at F000–FFFF).
- Decodes the ROM region and issues chip-select and address to the synchronous ROM.
- Waits the ROM's fixed read latency, captures the byte and returns it to the CPU with a one-cycle ready pulse.
- Holds a one-entry last-address cache, so repeated reads of the same location (vector fetch, tight loops) complete without a ROM access.

Parameters:
- ROM_LATENCY, 1, clock edges from rom_cs sampled high to rom_data valid. Legal values 1..3.
- ROM_BASE, 4'hF, value of cpu_addr[15:12] that selects the ROM region.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- cpu_req  in  1  CPU access request, level; held until cpu_rdy is seen high.
- cpu_rw  in  1  1 = read, 0 = write; sampled with cpu_req.
- cpu_addr  in  16  CPU address; stable while cpu_req is high.
- cpu_rdy  out  1  one-cycle completion pulse for ROM-region accesses.
- cpu_data  out  8  returned byte, registered; holds its value until the next completed read.
- rom_hit  out  1  combinational: cpu_req high and cpu_addr[15:12] == ROM_BASE.
- rom_cs  out  1  ROM chip select, registered.
- rom_addr  out  12  ROM address, registered (latched cpu_addr[11:0]).
- rom_data  in  8  ROM read data.
- wr_err  out  1  sticky flag: a write was attempted to the ROM region.
- err_clr  in  1  synchronous clear of wr_err.

Behaviour:
- Reset values (rst low, any time, including mid-access):
  - state IDLE
  - rom_cs 0, rom_addr 0, cpu_rdy 0, cpu_data 8'h00, wr_err 0
  - cache invalid, ACCESS counter 0
  - Any access in flight is abandoned; no cpu_rdy is produced for it.
- States: IDLE, ACCESS, DONE.
- IDLE, at a rising edge with rom_hit = 1 (this is edge E):
  - Read, cache valid and cpu_addr[11:0] == cached address: go to DONE; cpu_data unchanged. cpu_rdy is high in cycle E+1, with no ROM access.
  - Read, miss: latch cpu_addr[11:0] into rom_addr; rom_cs = 1; clear the counter; go to ACCESS.
  - Write: go to DONE; set wr_err; cpu_data and cache unchanged; rom_cs stays 0.
- IDLE with rom_hit = 0: stay in IDLE; cpu_rdy stays low, because other bus slaves own the acknowledge.
- ACCESS:
  - rom_cs stays high for the whole state; rom_addr is stable.
  - The counter increments on every edge.
  - On the edge where the counter equals ROM_LATENCY: capture rom_data into cpu_data; store rom_addr as the cached address; mark the cache valid; rom_cs goes 0; go to DONE.
  - Miss latency: cpu_rdy is high in cycle E+ROM_LATENCY+2, i.e. cycle E+3 for the default ROM_LATENCY = 1.
  - cpu_req dropping during ACCESS is a protocol error. The block still completes the access and pulses cpu_rdy.
- DONE:
  - cpu_rdy = 1 for exactly one cycle, then return to IDLE unconditionally.
  - A request still high at the DONE edge is treated as completed; it is not re-accepted.
  - A new request is sampled no earlier than the first IDLE edge after DONE.
- wr_err:
  - Set by any write to the ROM region.
  - err_clr clears it. If err_clr and a new ROM write occur on the same edge, set wins.
- Cache:
  - Validity is cleared only by reset.
  - The cached address compares all 12 bits, so F7FF and FFFF are distinct entries.
- cpu_data reflects only the last completed read; write acknowledges never alter it.

Test Plan:
- Reset release, then a read of FFFE with rom_data = 8'hA5 returned one edge after cs (L=1) -> rom_cs high for 2 cycles, rom_addr = 12'hFFE, cpu_rdy pulse in cycle E+3, cpu_data = 8'hA5.
- Immediate re-read of FFFE -> no rom_cs, cpu_rdy in cycle E+1, cpu_data = 8'hA5. Then a read of FFFF -> miss, full ROM access, new byte returned.
- Write to F123 -> cpu_rdy in cycle E+1, wr_err = 1, rom_cs stays 0, cpu_data unchanged. Pulse err_clr -> wr_err = 0. err_clr coincident with a second ROM write -> wr_err stays 1.
- Request to address 0400 -> rom_hit = 0, state stays IDLE, no cpu_rdy, no rom_cs.
- Assert rst low during ACCESS -> rom_cs, cpu_rdy and cpu_data go 0 asynchronously, with no rdy pulse afterward. The next read of the previously cached address misses and does a full ROM access.
- ROM_LATENCY = 3 build, read F800 -> rom_cs high for 4 cycles, cpu_rdy in cycle E+5. cpu_req held through DONE -> exactly one rdy pulse.

Source files
------------

// File: rtl/snd_rom_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : snd_rom_fetch
//  Description : Read sequencer between the sound CPU bus and the 4 KB sound
//                program ROM at F000-FFFF. Decodes the ROM region, drives the
//                synchronous ROM, waits its fixed latency, returns the byte
//                with a one-cycle ready pulse, and short-circuits repeated
//                reads through a one-entry last-address cache.
//  Revision    : 1.0 - initial release
// ============================================================================
module snd_rom_fetch #(
    parameter int         ROM_LATENCY = 1,     // legal 1..3
    parameter logic [3:0] ROM_BASE    = 4'hF
) (
    input  logic        clk,
    input  logic        rst,                   // asynchronous, active-low
    input  logic        cpu_req,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_addr,
    output logic        cpu_rdy,
    output logic [7:0]  cpu_data,
    output logic        rom_hit,
    output logic        rom_cs,
    output logic [11:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        wr_err,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Two bits cover every legal latency (1..3).
    localparam logic [1:0] c_lat = 2'(ROM_LATENCY);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cnt;
    logic        r_cache_vld;
    logic [11:0] r_cache_addr;
    logic        r_rom_cs;
    logic [11:0] r_rom_addr;
    logic [7:0]  r_cpu_data;
    logic        r_wr_err;

    logic        w_cache_hit;
    logic        w_miss_start;
    logic        w_wr_start;
    logic        w_capture;
    logic        w_rdy;

    // Region decode is purely combinational so other slaves can see it early.
    assign rom_hit     = cpu_req && (cpu_addr[15:12] == ROM_BASE);
    // All 12 offset bits take part, so the two 2 KB halves never alias.
    assign w_cache_hit = r_cache_vld && (cpu_addr[11:0] == r_cache_addr);

    // Next-state decode and the per-edge actions the datapath acts on.
    always_comb begin
        w_state_nxt  = r_state;
        w_miss_start = 1'b0;
        w_wr_start   = 1'b0;
        w_capture    = 1'b0;
        w_rdy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rom_hit) begin
                    if (!cpu_rw) begin
                        w_wr_start  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else if (w_cache_hit) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_miss_start = 1'b1;
                        w_state_nxt  = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                // The request is finished even if cpu_req drops meanwhile.
                if (r_cnt == c_lat) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Single acknowledge; a still-high request is not re-accepted.
                w_rdy       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ROM interface, latency counter, cache and returned-data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= 2'd0;
            r_rom_cs     <= 1'b0;
            r_rom_addr   <= 12'd0;
            r_cpu_data   <= 8'h00;
            r_cache_vld  <= 1'b0;
            r_cache_addr <= 12'd0;
        end else begin
            if (w_miss_start) begin
                r_rom_addr <= cpu_addr[11:0];
                r_rom_cs   <= 1'b1;
                r_cnt      <= 2'd0;
            end else if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt + 2'd1;
            end
            if (w_capture) begin
                r_cpu_data   <= rom_data;
                r_cache_addr <= r_rom_addr;
                r_cache_vld  <= 1'b1;
                r_rom_cs     <= 1'b0;
            end
        end
    end

    // Sticky write-to-ROM flag; a new offending write beats a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_err <= 1'b0;
        end else if (w_wr_start) begin
            r_wr_err <= 1'b1;
        end else if (err_clr) begin
            r_wr_err <= 1'b0;
        end
    end

    assign cpu_rdy  = w_rdy;
    assign cpu_data = r_cpu_data;
    assign rom_cs   = r_rom_cs;
    assign rom_addr = r_rom_addr;
    assign wr_err   = r_wr_err;

endmodule
`default_nettype wire
